// File: rtl/calc_pkg.sv
// ----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the accumulator calculator:
//   - command op-codes as presented on op_code
//   - controller state encoding
//   - saturation bound helpers (+max / -min of a two's-complement word)
// No ports; imported by calc_acc_unit and calc_seq_mul.
// ----------------------------------------------------------------------------
package calc_pkg;

    // Command op-codes
    localparam logic [2:0] OP_SHOW_IN  = 3'b000;
    localparam logic [2:0] OP_ADD      = 3'b001;
    localparam logic [2:0] OP_SUB      = 3'b010;
    localparam logic [2:0] OP_SHOW_ACC = 3'b011;
    localparam logic [2:0] OP_CLR      = 3'b100;
    localparam logic [2:0] OP_MUL      = 3'b101;

    // Controller states; the two unused encodings fall back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01
    } state_t;

    // Widest data word the saturation helpers can describe.
    localparam int MAX_WIDTH = 64;

    // Largest positive value of a width-bit signed word, in the low bits.
    function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width - 1) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Most negative value of a width-bit signed word, in the low bits.
    function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i == width - 1) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/calc_seq_mul.sv
// ----------------------------------------------------------------------------
// calc_seq_mul
// Iterative signed multiplier. Works on operand magnitudes with one shift-add
// step per clock and applies the sign to the finished magnitude product.
// The first step is taken on the start edge itself, so the last step lands
// WIDTH-1 edges later and done is high for the WIDTH-th cycle after start;
// the caller writes product on the edge that ends that cycle.
//
// Ports
//   clk      in   1        clock
//   reset    in   1        asynchronous, active-high reset (aborts a multiply)
//   start    in   1        capture a/b and begin; ignored while running
//   a        in   WIDTH    signed multiplicand
//   b        in   WIDTH    signed multiplier
//   done     out  1        product is final this cycle
//   product  out  2*WIDTH  signed full-width product
// ----------------------------------------------------------------------------
module calc_seq_mul
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Magnitudes as unsigned WIDTH-bit values; |-2^(WIDTH-1)| still fits.
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [2*WIDTH-1:0] partial;   // running magnitude product
    logic [2*WIDTH-1:0] mcand;     // multiplicand shifted to the next bit weight
    logic [WIDTH-1:0]   mplier;    // multiplier bits not yet consumed, LSB next
    logic               neg;       // sign of the final product
    logic               running;
    logic [CW-1:0]      cnt;       // steps completed after the start step

    assign mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the datapath registers are reset too, so a multiply aborted by
            // reset can never leak a stale partial product into a later result.
            partial <= '0;
            mcand   <= '0;
            mplier  <= '0;
            neg     <= 1'b0;
            running <= 1'b0;
            cnt     <= '0;
        end else if (start && !running) begin
            // NOTE: clocked state is written with non-blocking assignments only, so
            // every register here sees the pre-edge value of every other one.
            partial <= mag_b[0] ? {{WIDTH{1'b0}}, mag_a} : '0;
            mcand   <= {{(WIDTH-1){1'b0}}, mag_a, 1'b0};
            mplier  <= mag_b >> 1;
            neg     <= a[WIDTH-1] ^ b[WIDTH-1];
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (cnt == LAST) begin
                // Product was consumed on this edge.
                running <= 1'b0;
            end else begin
                if (mplier[0]) begin
                    partial <= partial + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end

    assign done    = running && (cnt == LAST);
    assign product = neg ? (~partial + 1'b1) : partial;

endmodule

// File: rtl/calc_acc_unit.sv
// ----------------------------------------------------------------------------
// calc_acc_unit
// Accumulator calculator between the command decoder and the display driver.
// Accepts one command per cycle over a valid/ready handshake; multiply takes
// WIDTH cycles, during which no new command is accepted.
//
// Parameters
//   WIDTH     data width of operand, accumulator and result (>= 4)
//   SATURATE  1: clamp overflowing ADD/SUB/MUL; 0: wrap modulo 2^WIDTH
//   MUL_EN    1: op 101 multiplies; 0: op 101 is reserved
//
// Ports
//   clk           in   1      clock
//   reset         in   1      asynchronous, active-high reset
//   op_valid      in   1      command present
//   op_ready      out  1      command accepted on this cycle's edge if valid
//   op_code       in   3      command code, sampled on accept
//   operand       in   WIDTH  signed operand, sampled on accept
//   result        out  WIDTH  display value register
//   result_valid  out  1      one-cycle pulse after a command completes
//   acc           out  WIDTH  accumulator register
//   overflow      out  1      sticky signed-overflow flag (cleared by CLR)
//   busy          out  1      multiply in progress (inverse of op_ready)
// ----------------------------------------------------------------------------
module calc_acc_unit
    import calc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0,
    parameter bit MUL_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [WIDTH-1:0] acc,
    output logic             overflow,
    output logic             busy
);

    localparam logic [MAX_WIDTH-1:0] SAT_MAX_FULL = sat_max(WIDTH);
    localparam logic [MAX_WIDTH-1:0] SAT_MIN_FULL = sat_min(WIDTH);
    localparam logic [WIDTH-1:0]     SAT_MAX      = SAT_MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SAT_MIN      = SAT_MIN_FULL[WIDTH-1:0];

    state_t             state;
    logic               accept;
    logic               start_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;

    // Handshake is a pure function of the state register.
    assign op_ready  = (state == ST_IDLE);
    assign busy      = ~op_ready;
    assign accept    = op_valid & op_ready;
    assign start_mul = accept & MUL_EN & (op_code == OP_MUL);

    // Pick the stored value for an arithmetic result: clamp toward the true
    // sign when saturating, otherwise keep the wrapped low bits.
    function automatic logic [WIDTH-1:0] fit(input logic             ovf,
                                             input logic             negative,
                                             input logic [WIDTH-1:0] wrapped);
        if (ovf && SATURATE) begin
            return negative ? SAT_MIN : SAT_MAX;
        end
        return wrapped;
    endfunction

    // ------------------------------------------------------------------
    // ADD/SUB: one guard bit above the sign; the true sum is out of range
    // exactly when the guard and sign bits disagree, and the guard bit is
    // the true sign.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   ext_acc;
    logic [WIDTH:0]   ext_opd;
    logic [WIDTH:0]   sum;
    logic             add_ovf;
    logic [WIDTH-1:0] add_val;

    assign ext_acc = {acc[WIDTH-1], acc};
    assign ext_opd = {operand[WIDTH-1], operand};
    assign sum     = (op_code == OP_SUB) ? (ext_acc - ext_opd) : (ext_acc + ext_opd);
    assign add_ovf = sum[WIDTH] ^ sum[WIDTH-1];
    assign add_val = fit(add_ovf, sum[WIDTH], sum[WIDTH-1:0]);

    // ------------------------------------------------------------------
    // MUL: the 2W-bit product fits in W bits only when every bit from the
    // W-bit sign position upward is a copy of the product's sign.
    // ------------------------------------------------------------------
    logic             mul_ovf;
    logic [WIDTH-1:0] mul_val;

    assign mul_ovf = ~((&product[2*WIDTH-1:WIDTH-1]) | ~(|product[2*WIDTH-1:WIDTH-1]));
    assign mul_val = fit(mul_ovf, product[2*WIDTH-1], product[WIDTH-1:0]);

    // mul_done rises when the multiplier's step count reaches WIDTH-1, i.e.
    // in the WIDTH-th cycle after the accepting edge.
    calc_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (start_mul),
        .a       (acc),
        .b       (operand),
        .done    (mul_done),
        .product (product)
    );

    // ------------------------------------------------------------------
    // Controller and registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            acc          <= '0;
            result       <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        result_valid <= 1'b1;
                        case (op_code)
                            OP_SHOW_IN: begin
                                result <= operand;
                            end
                            OP_ADD, OP_SUB: begin
                                acc    <= add_val;
                                result <= '0;
                                if (add_ovf) begin
                                    overflow <= 1'b1;
                                end
                            end
                            OP_SHOW_ACC: begin
                                result <= acc;
                            end
                            OP_CLR: begin
                                acc      <= '0;
                                result   <= '0;
                                overflow <= 1'b0;
                            end
                            OP_MUL: begin
                                // With the multiplier disabled this is a reserved
                                // code: it still completes but changes nothing.
                                if (MUL_EN) begin
                                    state        <= ST_MUL;
                                    result_valid <= 1'b0;
                                end
                            end
                            default: begin
                                // Reserved codes complete without side effects.
                            end
                        endcase
                    end
                end

                ST_MUL: begin
                    if (mul_done) begin
                        acc          <= mul_val;
                        result       <= '0;
                        result_valid <= 1'b1;
                        state        <= ST_IDLE;
                        if (mul_ovf) begin
                            overflow <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
